ram_port_arbiter: RTL and testbench

// - Shares one port of the dual-port RAM between NREQ requesters (e.g. fetch, load/store, debug).
// - Arbitrates each cycle and drives the RAM port signals en/wen/addr/wdata.
// - Returns read data with a per-requester response pulse; one access per cycle at full throughput.
// - Optional lock keeps a grant on one requester for atomic read-modify-write sequences.

---
 rtl/ram_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares one RAM port between NREQ requesters with optional lock.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module ram_port_arbiter #(
  parameter int NREQ      = 2,
  parameter int NDATA     = 64,
  parameter int NDATABYTE = 4,
  localparam int NADDRBIT = $clog2(NDATA),
  localparam int DW       = NDATABYTE * 8,
  localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           i_req_valid,
  output logic [NREQ-1:0]           o_req_ready,
  input  logic [NREQ-1:0]           i_req_lock,
  input  logic [NREQ*NDATABYTE-1:0] i_req_wen,
  input  logic [NREQ*NADDRBIT-1:0]  i_req_addr,
  input  logic [NREQ*DW-1:0]        i_req_wdata,
  output logic [NREQ-1:0]           o_rsp_valid,
  output logic [DW-1:0]             o_rsp_rdata,
  output logic                      o_ram_en,
  output logic [NDATABYTE-1:0]      o_ram_wen,
  output logic [NADDRBIT-1:0]       o_ram_addr,
  output logic [DW-1:0]             o_ram_wdata,
  input  logic [DW-1:0]             i_ram_rdata
);

  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [NREQ-1:0]     rsp_valid_q;
  logic                rsp_read_q;
  logic [NREQ-1:0]     grant;
  logic [IW-1:0]       gidx;
  logic                found;
  logic                any_acc;
  logic                sel_lock;
`ifdef RAM_ARB_RR_EN
  logic [IW-1:0]       ptr_q, ptr_d;
`endif

  // Grant is suppressed during reset so the RAM never sees an access then.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    if (!reset) begin
      if (state_q == LOCKED) begin
        if (i_req_valid[owner_q]) begin
          grant[owner_q] = 1'b1;
          gidx           = owner_q;
        end
      end else begin
`ifdef RAM_ARB_RR_EN
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (int'(ptr_q) + k) % NREQ;
          if (!found && i_req_valid[idx]) begin
            grant[idx] = 1'b1;
            gidx       = IW'(idx);
            found      = 1'b1;
          end
        end
`else
        for (int k = 0; k < NREQ; k++) begin
          if (!found && i_req_valid[k]) begin
            grant[k] = 1'b1;
            gidx     = IW'(k);
            found    = 1'b1;
          end
        end
`endif
      end
    end
  end

  assign any_acc     = |grant;
  assign o_req_ready = grant;
  assign o_ram_en    = any_acc;

  always_comb begin
    o_ram_wen   = '0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    sel_lock    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        o_ram_wen   = i_req_wen[i*NDATABYTE +: NDATABYTE];
        o_ram_addr  = i_req_addr[i*NADDRBIT +: NADDRBIT];
        o_ram_wdata = i_req_wdata[i*DW +: DW];
        sel_lock    = i_req_lock[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (any_acc) begin
      if (state_q == ARB && sel_lock) begin
        state_d = LOCKED;
        owner_d = gidx;
      end else if (state_q == LOCKED && !sel_lock) begin
        state_d = ARB;
      end
    end
  end

`ifdef RAM_ARB_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (any_acc) begin
      ptr_d = (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ARB;
      owner_q     <= '0;
      rsp_valid_q <= '0;
      rsp_read_q  <= 1'b0;
`ifdef RAM_ARB_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rsp_valid_q <= grant;
      rsp_read_q  <= any_acc && (o_ram_wen == '0);
`ifdef RAM_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  // A response still in flight when reset rises is dropped immediately.
  assign o_rsp_valid = reset ? '0 : rsp_valid_q;
  assign o_rsp_rdata = (!reset && (|rsp_valid_q) && rsp_read_q) ? i_ram_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter with a registered-read RAM model.
module tb_ram_port_arbiter;
  localparam int NREQ  = 2;
  localparam int NDATA = 64;
  localparam int NB    = 4;
  localparam int AW    = 6;
  localparam int DW    = 32;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_lock;
  logic [NREQ*NB-1:0]   req_wen;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      rsp_valid;
  logic [DW-1:0]        rsp_rdata;
  logic                 ram_en;
  logic [NB-1:0]        ram_wen;
  logic [AW-1:0]        ram_addr;
  logic [DW-1:0]        ram_wdata;
  logic [DW-1:0]        ram_rdata;

  logic [DW-1:0]        mem    [NDATA];
  logic [DW-1:0]        shadow [NDATA];

  typedef struct {
    int            req;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;
  int ptr_m       = 0;

  always #5 clock = ~clock;

  ram_port_arbiter #(.NREQ(NREQ), .NDATA(NDATA), .NDATABYTE(NB)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_lock  (req_lock),
    .i_req_wen   (req_wen),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_ram_en    (ram_en),
    .o_ram_wen   (ram_wen),
    .o_ram_addr  (ram_addr),
    .o_ram_wdata (ram_wdata),
    .i_ram_rdata (ram_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 5) return 32'hDEADBEEF;
    return 32'h1000_0000 + DW'(i) * 32'h0101;
  endfunction

  // RAM model: reloads its contents during reset, read-first registered output.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NDATA; i++) mem[i] <= init_word(i);
    end else if (ram_en) begin
      for (int b = 0; b < NB; b++)
        if (ram_wen[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] exp_grant(input logic [NREQ-1:0] v);
    logic [NREQ-1:0] g;
    g = '0;
`ifdef RAM_ARB_RR_EN
    for (int k = NREQ - 1; k >= 0; k--)
      if (v[(ptr_m + k) % NREQ]) g = NREQ'(1) << ((ptr_m + k) % NREQ);
`else
    for (int k = NREQ - 1; k >= 0; k--)
      if (v[k]) g = NREQ'(1) << k;
`endif
    return g;
  endfunction

  task automatic clear_reqs();
    req_valid = '0;
    req_lock  = '0;
    req_wen   = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic lk, input logic [NB-1:0] wen,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
    req_valid[i]          = v;
    req_lock[i]           = lk;
    req_wen[i*NB +: NB]   = wen;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = wd;
  endtask

  // One clock: check the response owed by last cycle, the grant, the RAM port, then log this accept.
  task automatic cycle(input logic [NREQ-1:0] exp_rdy);
    rsp_t          e;
    int            g;
    logic [NB-1:0] wen;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    @(negedge clock);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rsp_valid", 64'(rsp_valid), 64'(1) << e.req);
      check("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
    end else begin
      check("rsp_idle", 64'(rsp_valid), 64'(0));
      check("rsp_rdata_idle", 64'(rsp_rdata), 64'(0));
    end
    check("ready", 64'(req_ready), 64'(exp_rdy));
    check("ram_en", 64'(ram_en), 64'(|exp_rdy));
    if (exp_rdy == '0) begin
      check("ram_idle", 64'({ram_wen, ram_addr, ram_wdata}), 64'(0));
    end else begin
      g = 0;
      for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) g = i;
      wen = req_wen[g*NB +: NB];
      a   = req_addr[g*AW +: AW];
      wd  = req_wdata[g*DW +: DW];
      check("ram_port", 64'({ram_wen, ram_addr, ram_wdata}), 64'({wen, a, wd}));
      e.req = g;
      if (wen == '0) begin
        e.data = shadow[a];
      end else begin
        e.data = '0;
        for (int b = 0; b < NB; b++) if (wen[b]) shadow[a][b*8 +: 8] = wd[b*8 +: 8];
      end
      sb.push_back(e);
      ptr_m = (g + 1) % NREQ;
    end
    if (reset) begin
      for (int i = 0; i < NDATA; i++) shadow[i] = init_word(i);
      ptr_m = 0;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NDATA; i++) shadow[i] = init_word(i);
    reset = 1'b1;
    clear_reqs();
    req_valid = '1;
    @(posedge clock);
    #1;
    cycle(2'b00);
    cycle(2'b00);
    reset = 1'b0;
    clear_reqs();

    // single read of the preloaded word
    set_req(0, 1'b1, 1'b0, 4'b0000, 6'd5, 32'h0);
    cycle(2'b01);
    clear_reqs();
    cycle(2'b00);

    // byte write then read back
    set_req(1, 1'b1, 1'b0, 4'b0010, 6'd3, 32'h0000AB00);
    cycle(2'b10);
    set_req(1, 1'b1, 1'b0, 4'b0000, 6'd3, 32'h0);
    cycle(2'b10);
    clear_reqs();
    cycle(2'b00);

    // contention
    set_req(0, 1'b1, 1'b0, 4'b0000, 6'd1, 32'h0);
    set_req(1, 1'b1, 1'b0, 4'b0000, 6'd2, 32'h0);
    for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_RR_EN
      cycle((k % 2 == 1) ? 2'b10 : 2'b01);
`else
      cycle(2'b01);
`endif
    end
    clear_reqs();
    cycle(2'b00);

    // lock: owner idle stalls others, unlock write releases
    set_req(1, 1'b1, 1'b1, 4'b0000, 6'd7, 32'h0);
    cycle(2'b10);
    set_req(1, 1'b0, 1'b0, 4'b0000, 6'd0, 32'h0);
    set_req(0, 1'b1, 1'b0, 4'b0000, 6'd7, 32'h0);
    cycle(2'b00);
    set_req(1, 1'b1, 1'b0, 4'b1111, 6'd7, 32'hCAFE_F00D);
    cycle(2'b10);
    set_req(1, 1'b0, 1'b0, 4'b0000, 6'd0, 32'h0);
    cycle(2'b01);
    clear_reqs();
    cycle(2'b00);

    // reset while locked with a response pending
    set_req(1, 1'b1, 1'b1, 4'b0000, 6'd9, 32'h0);
    cycle(2'b10);
    reset = 1'b1;
    set_req(0, 1'b1, 1'b0, 4'b1111, 6'd9, 32'h1234_5678);
    set_req(1, 1'b1, 1'b1, 4'b1111, 6'd9, 32'h8765_4321);
    sb.delete();
    cycle(2'b00);
    reset = 1'b0;
    clear_reqs();
    set_req(0, 1'b1, 1'b0, 4'b0000, 6'd9, 32'h0);
    cycle(2'b01);
    clear_reqs();
    cycle(2'b00);

    // random unlocked traffic
    for (int n = 0; n < 24; n++) begin
      logic [NREQ-1:0] v;
      v = NREQ'($urandom_range(0, 3));
      for (int i = 0; i < NREQ; i++)
        set_req(i, v[i], 1'b0, ($urandom_range(0, 1) == 1) ? NB'($urandom) : 4'b0000,
                AW'($urandom), $urandom);
      cycle(exp_grant(v));
    end
    clear_reqs();
    cycle(2'b00);
    cycle(2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
